gate_truth_checker: RTL and testbench

Synthesizable self-checking responder for the logic-gate library. It drives all four input combinations of a 2-input gate under test, waits a fixed settle time, samples the gate output and compares it against a parameterized expected truth table. It produces a pass/fail verdict, a mismatch count, the first failing vector and the observed truth table. It sits opposite the gate, in place of a simulation-only stimulus/display bench, so gate checks can run on hardware or in lint-clean RTL regressions.

---
 rtl/gate_truth_checker.sv | 107 ++++++++++
 tb/tb_gate_truth_checker.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: drives all four {a,b} vectors into a 2-input gate and checks y against a truth table
module gate_truth_checker #(
  parameter logic [3:0] EXPECTED      = 4'b0001,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic       fail_valid,
  output logic [1:0] first_fail_idx,
  output logic [3:0] observed_tt
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);
  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] err_q, err_d;
  logic       fv_q, fv_d;
  logic [1:0] ffi_q, ffi_d;
  logic [3:0] ott_q, ott_d;
  logic       done_q, done_d;
  logic       miss;
  assign miss = y_in != EXPECTED[idx_q];
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ffi_d   = ffi_q;
    ott_d   = ott_q;
    done_d  = done_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = SETTLE;
        idx_d   = '0;
        cnt_d   = '0;
        err_d   = '0;
        fv_d    = 1'b0;
        ffi_d   = '0;
        ott_d   = '0;
        done_d  = 1'b0;
      end
      SETTLE: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = cnt_q == LAST ? SAMPLE : SETTLE;
      end
      SAMPLE: begin
        ott_d[idx_q] = y_in;
        if (miss) begin
          err_d = err_q + 3'd1;
          if (!fv_q) begin
            ffi_d = idx_q;
            fv_d  = 1'b1;
          end
        end
        if (idx_q == 2'd3) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ffi_q   <= '0;
      ott_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ffi_q   <= ffi_d;
      ott_q   <= ott_d;
      done_q  <= done_d;
    end
  end
  // the vector index doubles as the driven {a,b} pair, so DONE naturally holds 2'b11
  assign {a_out, b_out}  = idx_q;
  assign busy            = state_q == SETTLE || state_q == SAMPLE;
  assign done            = done_q;
  assign pass            = done_q && err_q == 3'd0;
  assign err_count       = err_q;
  assign fail_valid      = fv_q;
  assign first_fail_idx  = ffi_q;
  assign observed_tt     = ott_q;
endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker: table-driven and random gate checks against a truth-table reference model
module tb_gate_truth_checker;
  localparam logic [3:0] EXP = 4'b0001;
  logic clk = 0, rst = 1, start0 = 0, start1 = 0, sel = 0;
  logic [3:0] gate_tt = EXP;
  logic a0, b0, y0, busy0, done0, pass0, fv0;
  logic a1, b1, y1, busy1, done1, pass1, fv1;
  logic [2:0] err0, err1;
  logic [1:0] ffi0, ffi1;
  logic [3:0] ott0, ott1;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign y0 = gate_tt[{a0, b0}];
  assign y1 = gate_tt[{a1, b1}];
  gate_truth_checker #(.EXPECTED(EXP), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start0), .a_out(a0), .b_out(b0), .y_in(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_valid(fv0),
    .first_fail_idx(ffi0), .observed_tt(ott0));
  gate_truth_checker #(.EXPECTED(EXP), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1), .y_in(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_valid(fv1),
    .first_fail_idx(ffi1), .observed_tt(ott1));
  logic       a_s, b_s, busy_s, done_s, pass_s, fv_s;
  logic [2:0] err_s;
  logic [1:0] ffi_s;
  logic [3:0] ott_s;
  assign {a_s, b_s, busy_s, done_s, pass_s, fv_s} = sel ? {a1, b1, busy1, done1, pass1, fv1}
                                                        : {a0, b0, busy0, done0, pass0, fv0};
  assign {err_s, ffi_s, ott_s} = sel ? {err1, ffi1, ott1} : {err0, ffi0, ott0};
  typedef struct {
    logic [3:0] tt;
    int         err;
    logic       fv;
    int         ffi;
    logic       pass;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic drive_start(input logic v);
    if (sel) start1 = v; else start0 = v;
  endtask
  task automatic check_result(input string nm, input logic [3:0] tt, input int err,
                              input logic fv, input int ffi, input logic ps);
    chk({nm, " err_count"}, int'(err_s), err);
    chk({nm, " fail_valid"}, int'(fv_s), int'(fv));
    chk({nm, " first_fail_idx"}, int'(ffi_s), ffi);
    chk({nm, " observed_tt"}, int'(ott_s), int'(tt));
    chk({nm, " pass"}, int'(pass_s), int'(ps));
    chk({nm, " ab_hold"}, int'({a_s, b_s}), 3);
    chk({nm, " busy_end"}, int'(busy_s), 0);
  endtask
  // one full run: start pulse, optional ignored start at edge 'glitch', latency and a/b stepping checks
  task automatic run(input string nm, input logic s, input logic [3:0] tt, input int glitch, input bit chk_ab);
    int n, per;
    sel = s;
    gate_tt = tt;
    per = s ? 2 : 3;
    @(negedge clk);
    drive_start(1);
    @(posedge clk); #1;
    drive_start(0);
    chk({nm, " busy_after_start"}, int'(busy_s), 1);
    chk({nm, " done_cleared"}, int'(done_s), 0);
    n = 0;
    while (!done_s && n < 40) begin
      if (chk_ab) chk($sformatf("%s ab@%0d", nm, n), int'({a_s, b_s}), n / per);
      @(posedge clk); #1;
      n++;
      drive_start(n == glitch);
    end
    drive_start(0);
    chk({nm, " done_latency"}, n, 4 * per);
  endtask
  // reference: mismatches are the set bits of observed ^ expected
  task automatic model(input logic [3:0] tt, output int err, output logic fv, output int ffi, output logic ps);
    logic [3:0] d;
    d = tt ^ EXP;
    err = $countones(d);
    fv = d != 0;
    ffi = 0;
    for (int i = 3; i >= 0; i--) if (d[i]) ffi = i;
    ps = err == 0;
  endtask
  initial begin
    int err, ffi;
    logic fv, ps;
    logic [3:0] rt;
    tbl[0] = '{4'b0001, 0, 1'b0, 0, 1'b1};
    tbl[1] = '{4'b1110, 4, 1'b1, 0, 1'b0};
    tbl[2] = '{4'b0101, 1, 1'b1, 2, 1'b0};
    tbl[3] = '{4'b1000, 2, 1'b1, 0, 1'b0};
    tbl[4] = '{4'b0110, 3, 1'b1, 0, 1'b0};
    tbl[5] = '{4'b1111, 3, 1'b1, 1, 1'b0};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset busy", int'(busy0), 0);
    chk("reset done", int'(done0), 0);
    chk("reset pass", int'(pass0), 0);
    chk("reset ab", int'({a0, b0}), 0);
    chk("reset err", int'(err0), 0);
    chk("reset ott", int'(ott0), 0);
    for (int i = 0; i < 6; i++) begin
      run($sformatf("tbl%0d", i), 1'b0, tbl[i].tt, 0, i == 0);
      check_result($sformatf("tbl%0d", i), tbl[i].tt, tbl[i].err, tbl[i].fv, tbl[i].ffi, tbl[i].pass);
    end
    run("settle1", 1'b1, 4'b0001, 0, 1'b1);
    check_result("settle1", 4'b0001, 0, 1'b0, 0, 1'b1);
    run("glitch", 1'b0, 4'b0001, 5, 1'b1);
    check_result("glitch", 4'b0001, 0, 1'b0, 0, 1'b1);
    run("rerun", 1'b0, 4'b0001, 0, 1'b1);
    check_result("rerun", 4'b0001, 0, 1'b0, 0, 1'b1);
    sel = 0;
    gate_tt = 4'b1110;
    @(negedge clk); start0 = 1;
    @(posedge clk); #1 start0 = 0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst idx", int'({a0, b0}), 2);
    chk("pre_rst err", int'(err0), 2);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("rst busy", int'(busy0), 0);
    chk("rst done", int'(done0), 0);
    chk("rst ab", int'({a0, b0}), 0);
    chk("rst err", int'(err0), 0);
    chk("rst fv", int'(fv0), 0);
    chk("rst ffi", int'(ffi0), 0);
    chk("rst ott", int'(ott0), 0);
    run("after_rst", 1'b0, 4'b0001, 0, 1'b0);
    check_result("after_rst", 4'b0001, 0, 1'b0, 0, 1'b1);
    @(negedge clk); start0 = 1; rst = 1;
    @(posedge clk); #1 start0 = 0; rst = 0;
    chk("start_rst busy", int'(busy0), 0);
    chk("start_rst done", int'(done0), 0);
    for (int i = 0; i < 20; i++) begin
      rt = 4'($urandom);
      model(rt, err, fv, ffi, ps);
      run($sformatf("rnd%0d", i), 1'($urandom), rt, 0, 1'b0);
      check_result($sformatf("rnd%0d", i), rt, err, fv, ffi, ps);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
